// File: rtl/vib_axis_pkg.sv
// Shared definitions for vibrometer AXI-Stream blocks: mode enum, clog2 helper
// and default widths.
package vib_axis_pkg;

    typedef enum logic {
        MODE_PICK = 1'b0,
        MODE_AVG  = 1'b1
    } mode_e;

    localparam int unsigned DEF_TDATA_WIDTH      = 32;
    localparam int unsigned DEF_CHANNELS         = 2;
    localparam int unsigned DEF_MAX_LOG_THROTTLE = 16;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_decimator_if.sv
// AXI-Stream data/valid/ready bundle with master and slave views.
interface axis_decimator_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/axis_decimator_lane.sv
// One signed lane of the averaging decimator: group accumulator plus the
// final arithmetic shift by the group exponent.
module axis_decimator_lane
    import vib_axis_pkg::*;
#(
    parameter int unsigned LW               = 16,
    parameter int unsigned MAX_LOG_THROTTLE = 16,
    parameter int unsigned NW               = 5
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          i_en,
    input  logic          i_first,
    input  logic          i_last,
    input  logic [NW-1:0] i_n,
    input  logic [LW-1:0] i_data,
    output logic [LW-1:0] o_result
);

    localparam int unsigned AW = LW + MAX_LOG_THROTTLE;

    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_ext;
    logic signed [AW-1:0] w_sum;

    assign w_ext = {{MAX_LOG_THROTTLE{i_data[LW-1]}}, i_data};

    // The first beat of a group replaces whatever the previous group left behind.
    assign w_sum    = (i_first ? '0 : r_acc) + w_ext;
    assign o_result = LW'(w_sum >>> i_n);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_acc <= '0;
        end else if (i_en && !i_last) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/axis_decimator.sv
// AXI-Stream decimator by 2^log_throttle (pick-last or per-lane average).
// Define AXIS_DECIMATOR_AVG_EN to compile in the averaging lanes.
module axis_decimator
    import vib_axis_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int unsigned CHANNELS         = DEF_CHANNELS,
    parameter int unsigned MAX_LOG_THROTTLE = DEF_MAX_LOG_THROTTLE
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [4:0]           log_throttle,
    input  logic                 avg_mode,
    axis_decimator_if.slave      S_AXIS,
    axis_decimator_if.master     M_AXIS,
    output logic [31:0]          group_count
);

    localparam int unsigned LW = AXIS_TDATA_WIDTH / CHANNELS;
    localparam int unsigned NW = clog2(MAX_LOG_THROTTLE + 1);
    localparam int unsigned CW = (MAX_LOG_THROTTLE > 0) ? MAX_LOG_THROTTLE : 1;

    logic                        r_run;
    logic [CW-1:0]               r_cnt;
    logic [NW-1:0]               r_n;
    mode_e                       r_mode;
    logic                        r_mvalid;
    logic [AXIS_TDATA_WIDTH-1:0] r_mdata;
    logic [31:0]                 r_group_count;

    logic                        w_in_acc;
    logic                        w_out_acc;
    logic                        w_first;
    logic                        w_last;
    logic [NW-1:0]               w_n_clamped;
    logic [NW-1:0]               w_n;
    mode_e                       w_mode_in;
    mode_e                       w_mode;
    logic [CW-1:0]               w_limit;
    logic [AXIS_TDATA_WIDTH-1:0] w_avg_word;
    logic [AXIS_TDATA_WIDTH-1:0] w_out_word;

    assign S_AXIS.tready = r_run && (!r_mvalid || M_AXIS.tready);
    assign M_AXIS.tvalid = r_mvalid;
    assign M_AXIS.tdata  = r_mdata;
    assign group_count   = r_group_count;

    assign w_in_acc  = S_AXIS.tvalid && S_AXIS.tready;
    assign w_out_acc = r_mvalid && M_AXIS.tready;

    assign w_n_clamped = (32'(log_throttle) > MAX_LOG_THROTTLE) ? NW'(MAX_LOG_THROTTLE)
                                                                : NW'(log_throttle);

    // Group parameters come straight from the inputs on the first beat, so a
    // one-beat group (n = 0) is already decided with the new exponent.
    assign w_first = (r_cnt == '0);
    assign w_n     = w_first ? w_n_clamped : r_n;
    assign w_mode  = w_first ? w_mode_in : r_mode;
    assign w_limit = ~({CW{1'b1}} << w_n);
    assign w_last  = (r_cnt == w_limit);

`ifdef AXIS_DECIMATOR_AVG_EN
    assign w_mode_in = mode_e'(avg_mode);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        axis_decimator_lane #(
            .LW               (LW),
            .MAX_LOG_THROTTLE (MAX_LOG_THROTTLE),
            .NW               (NW)
        ) u_lane (
            .aclk     (aclk),
            .aresetn  (aresetn),
            .i_en     (w_in_acc),
            .i_first  (w_first),
            .i_last   (w_last),
            .i_n      (w_n),
            .i_data   (S_AXIS.tdata[k*LW +: LW]),
            .o_result (w_avg_word[k*LW +: LW])
        );
    end
`else
    // Pick-only build: the mode port stays for compatibility but reads as pick.
    assign w_mode_in  = mode_e'(avg_mode & 1'b0);
    assign w_avg_word = S_AXIS.tdata;
`endif

    assign w_out_word = (w_mode == MODE_AVG) ? w_avg_word : S_AXIS.tdata;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_run         <= 1'b0;
            r_cnt         <= '0;
            r_n           <= '0;
            r_mode        <= MODE_PICK;
            r_mvalid      <= 1'b0;
            r_mdata       <= '0;
            r_group_count <= '0;
        end else begin
            r_run <= 1'b1;

            if (w_in_acc) begin
                if (w_first) begin
                    r_n    <= w_n_clamped;
                    r_mode <= w_mode_in;
                end
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                if (w_last) begin
                    r_mdata <= w_out_word;
                end
            end

            if (w_in_acc && w_last) begin
                r_mvalid <= 1'b1;
            end else if (w_out_acc) begin
                r_mvalid <= 1'b0;
            end

            if (w_out_acc) begin
                r_group_count <= r_group_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_decimator.sv
// Self-checking bench for axis_decimator: directed scenarios plus random
// traffic against a group-level reference model.
module tb_axis_decimator;

    localparam int unsigned W   = 32;
    localparam int unsigned CH  = 2;
    localparam int unsigned LW  = W / CH;
    localparam int unsigned MAXN = 16;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [4:0]  log_throttle;
    logic        avg_mode;
    logic        s_valid;
    logic [31:0] s_tdata;
    logic        m_ready;
    logic [31:0] group_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    axis_decimator_if #(.WIDTH(W)) s_if ();
    axis_decimator_if #(.WIDTH(W)) m_if ();

    assign s_if.tdata  = s_tdata;
    assign s_if.tvalid = s_valid;
    assign m_if.tready = m_ready;

    axis_decimator #(
        .AXIS_TDATA_WIDTH (W),
        .CHANNELS         (CH),
        .MAX_LOG_THROTTLE (MAXN)
    ) dut (
        .aclk         (clk),
        .aresetn      (aresetn),
        .log_throttle (log_throttle),
        .avg_mode     (avg_mode),
        .S_AXIS       (s_if),
        .M_AXIS       (m_if),
        .group_count  (group_count)
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, expv);
        end
    endtask

    // Group mean per lane, floored, from the raw sample list.
    function automatic logic [31:0] avg_word(input logic [31:0] q[$], input int n);
        logic [31:0] w;
        logic [15:0] v;
        longint      s;
        longint      d;
        longint      f;
        w = '0;
        for (int k = 0; k < CH; k++) begin
            s = 0;
            foreach (q[i]) begin
                v = q[i][k*LW +: LW];
                s += longint'($signed(v));
            end
            d = longint'(1) << n;
            f = s / d;
            if ((s % d) != 0 && s < 0) f -= 1;
            w[k*LW +: LW] = f[15:0];
        end
        return w;
    endfunction

    // Reference model: what the outputs should look like after each edge.
    logic        live = 1'b0;
    logic        mdl_run, mdl_ov;
    logic [31:0] mdl_od, mdl_gc;
    logic [31:0] grp[$];
    int          grp_n;
    logic        grp_avg;
    logic [31:0] got_q[$];

    always @(negedge clk) begin
        logic        oa, ia, load, exp_ready;
        logic [31:0] nw;
        if (live) begin
            exp_ready = mdl_run && (!mdl_ov || m_ready);
            check("tvalid", m_if.tvalid, mdl_ov);
            check("tdata", m_if.tdata, mdl_od);
            check("tready", s_if.tready, exp_ready);
            check("group_count", group_count, mdl_gc);
        end
        if (!aresetn) begin
            live    = 1'b1;
            mdl_run = 1'b0;
            mdl_ov  = 1'b0;
            mdl_od  = '0;
            mdl_gc  = '0;
            grp.delete();
        end else if (live) begin
            oa   = mdl_ov && m_ready;
            ia   = s_valid && mdl_run && (!mdl_ov || m_ready);
            load = 1'b0;
            nw   = '0;
            if (oa) got_q.push_back(m_if.tdata);
            if (ia) begin
                if (grp.size() == 0) begin
                    grp_n = (int'(log_throttle) > int'(MAXN)) ? int'(MAXN) : int'(log_throttle);
`ifdef AXIS_DECIMATOR_AVG_EN
                    grp_avg = avg_mode;
`else
                    grp_avg = 1'b0;
`endif
                end
                grp.push_back(s_tdata);
                if (grp.size() == (1 << grp_n)) begin
                    nw   = grp_avg ? avg_word(grp, grp_n) : s_tdata;
                    load = 1'b1;
                    grp.delete();
                end
            end
            if (load) begin
                mdl_ov = 1'b1;
                mdl_od = nw;
            end else if (oa) begin
                mdl_ov = 1'b0;
            end
            if (oa) mdl_gc = mdl_gc + 1;
            mdl_run = 1'b1;
        end
    end

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int c);
        @(posedge clk);
        #1 aresetn = 1'b0;
        repeat (c) @(posedge clk);
        #1 aresetn = 1'b1;
    endtask

    // Present one beat and hold it until accepted; reports stall cycles.
    task automatic send(input logic [31:0] w, output int unsigned waits);
        logic        acc;
        int unsigned guard;
        guard   = 0;
        waits   = 0;
        s_tdata = w;
        s_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int unsigned wt, wsum;
        logic [31:0] sent[$];
        logic [31:0] tmp;
        logic        acc;
        aresetn      = 1'b0;
        log_throttle = '0;
        avg_mode     = 1'b0;
        s_valid      = 1'b0;
        s_tdata      = '0;
        m_ready      = 1'b1;
        idle(3);
        #1 aresetn = 1'b1;
        idle(2);

        // Pick, n = 3, beats 0..15
        got_q.delete();
        log_throttle = 5'd3;
        for (int i = 0; i < 16; i++) send(32'(i), wt);
        s_valid = 1'b0;
        idle(3);
        check("t1_outputs", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("t1_out0", got_q[0], 32'd7);
            check("t1_out1", got_q[1], 32'd15);
        end
        check("t1_count", group_count, 32'd2);

        // Average, n = 2, signed lanes
        got_q.delete();
        log_throttle = 5'd2;
        avg_mode     = 1'b1;
        send({16'hFFFF, 16'd4}, wt);
        send({16'hFFFE, 16'd5}, wt);
        send({16'hFFFD, 16'd6}, wt);
        send({16'hFFFC, 16'd7}, wt);
        s_valid = 1'b0;
        idle(3);
        check("t2_outputs", 32'(got_q.size()), 32'd1);
`ifdef AXIS_DECIMATOR_AVG_EN
        if (got_q.size() == 1) check("t2_avg", got_q[0], 32'hFFFD_0005);
`else
        if (got_q.size() == 1) check("t2_pick", got_q[0], 32'hFFFC_0007);
`endif
        avg_mode = 1'b0;

        // n = 0, continuous: every beat passes, no stalls
        got_q.delete();
        sent.delete();
        log_throttle = 5'd0;
        wsum = 0;
        for (int i = 0; i < 20; i++) begin
            tmp = $urandom;
            sent.push_back(tmp);
            send(tmp, wt);
            wsum += wt;
        end
        s_valid = 1'b0;
        idle(3);
        check("t3_stalls", wsum, 32'd0);
        check("t3_outputs", 32'(got_q.size()), 32'd20);
        if (got_q.size() == 20)
            for (int i = 0; i < 20; i++) check("t3_passthru", got_q[i], sent[i]);

        // Backpressure, n = 1
        got_q.delete();
        log_throttle = 5'd1;
        wsum = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(32'(i), wt);
                    wsum += wt;
                end
                s_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 100; c++) begin
                    @(negedge clk);
                    if (m_if.tvalid) break;
                end
                @(posedge clk);
                #1 m_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 m_ready = 1'b1;
            end
        join
        idle(3);
        check("t4_stalled", 32'(wsum > 0), 32'd1);
        check("t4_outputs", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("t4_out0", got_q[0], 32'd1);
            check("t4_out1", got_q[1], 32'd3);
            check("t4_out2", got_q[2], 32'd5);
        end

        // Exponent change mid-group
        got_q.delete();
        log_throttle = 5'd3;
        for (int i = 0; i < 12; i++) begin
            send(32'(100 + i), wt);
            if (i == 1) log_throttle = 5'd1;
        end
        s_valid = 1'b0;
        idle(3);
        check("t5_outputs", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("t5_out0", got_q[0], 32'd107);
            check("t5_out1", got_q[1], 32'd109);
            check("t5_out2", got_q[2], 32'd111);
        end

        // Clamped exponent: 40 beats never close a group
        got_q.delete();
        log_throttle = 5'd31;
        for (int i = 0; i < 40; i++) send($urandom, wt);
        s_valid = 1'b0;
        idle(3);
        check("t6_clamp_none", 32'(got_q.size()), 32'd0);
        do_reset(2);
        idle(2);

        // Reset while an output is held and a group is partial
        log_throttle = 5'd2;
        m_ready      = 1'b0;
        for (int i = 0; i < 4; i++) send(32'(200 + i), wt);
        s_tdata = 32'd300;
        idle(2);
        s_valid = 1'b0;
        check("t7_held", m_if.tvalid, 1'b1);
        do_reset(2);
        @(negedge clk);
        check("t7_rst_tvalid", m_if.tvalid, 1'b0);
        check("t7_rst_count", group_count, 32'd0);
        idle(1);
        got_q.delete();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(32'(400 + i), wt);
        s_valid = 1'b0;
        idle(3);
        check("t7_partial", 32'(got_q.size()), 32'd0);
        send(32'd403, wt);
        s_valid = 1'b0;
        idle(3);
        check("t7_outputs", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) check("t7_out", got_q[0], 32'd403);

        // Random traffic
        log_throttle = 5'd1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc = s_valid && s_if.tready;
            @(posedge clk);
            #1;
            if (acc || !s_valid) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_tdata = $urandom;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            if ((c % 64) == 0) begin
                log_throttle = 5'($urandom_range(0, 3));
                avg_mode     = 1'($urandom_range(0, 1));
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
